// File: rtl/mips32_pkg.sv
// mips32_pkg: shared definitions for the mips32_processor pipeline.
//   - opcode constants
//   - instruction-class enum and opcode classifier
//   - instruction field slicing helper
//   - pipeline register structs (ID/EX, EX/MEM, MEM/WB)
package mips32_pkg;

  localparam int unsigned NUM_REGS  = 32;
  localparam int unsigned MEM_WORDS = 1024;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {
    RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP
  } instr_class_e;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;   // sign-extended
  } fields_t;

  typedef struct packed {
    logic         valid;
    instr_class_e cls;
    logic [5:0]   op;
    logic [31:0]  npc;   // address of this instruction + 1
    logic [31:0]  a;     // rs value read in ID
    logic [31:0]  b;     // rt value read in ID
    logic [31:0]  imm;
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [4:0]   dest;
    logic         wr;    // writes a non-zero register
  } id_ex_t;

  typedef struct packed {
    logic         valid;
    instr_class_e cls;
    logic [31:0]  alu;
    logic [31:0]  b;     // store data
    logic [4:0]   dest;
    logic         wr;
  } ex_mem_t;

  typedef struct packed {
    logic         valid;
    instr_class_e cls;
    logic [31:0]  result;
    logic [4:0]   dest;
    logic         wr;
  } mem_wb_t;

  function automatic fields_t f_fields(input logic [31:0] ir);
    fields_t f;
    f.op  = ir[31:26];
    f.rs  = ir[25:21];
    f.rt  = ir[20:16];
    f.rd  = ir[15:11];
    f.imm = {{16{ir[15]}}, ir[15:0]};
    return f;
  endfunction

  function automatic instr_class_e f_class(input logic [5:0] op);
    instr_class_e c;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: c = RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     c = RM_ALU;
      OP_LW:                                         c = LOAD;
      OP_SW:                                         c = STORE;
      OP_BNEQZ, OP_BEQZ:                             c = BRANCH;
      OP_HLT:                                        c = HALT;
      default:                                       c = NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips32_alu.sv
// mips32_alu: combinational ALU for the EX stage.
//   op     in  6   instruction opcode (R-type and I-type share the decode)
//   a      in  32  rs operand
//   b      in  32  rt operand or sign-extended immediate
//   result out 32  ALU result; loads/stores and unknown opcodes get a + b
module mips32_alu
  import mips32_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  always_comb begin
    result = a + b;
    case (op)
      OP_SUB, OP_SUBI: result = a - b;
      OP_AND:          result = a & b;
      OP_OR:           result = a | b;
      OP_SLT, OP_SLTI: result = {31'd0, ($signed(a) < $signed(b))};
      OP_MUL:          result = a * b;   // low 32 bits of the product
      default:         ;
    endcase
  end

endmodule

// File: rtl/mips32_processor.sv
// mips32_processor: five-stage pipelined MIPS-subset core (IF ID EX MEM WB)
// with unified word-addressed memory Mem[0:1023] and register file Reg[0:31].
//   clk    in  1  clock, rising edge
//   rst_n  in  1  asynchronous active-low reset (Reg and Mem are not reset)
//   halted out 1  high once an HLT has retired
// Reg and Mem are preloaded hierarchically; PC, HALTED and TAKEN_BRANCH are
// kept under those names for observation.
module mips32_processor
  import mips32_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  output logic halted
);

  logic [31:0] Reg [0:NUM_REGS-1];
  logic [31:0] Mem [0:MEM_WORDS-1];
  logic [31:0] PC, pc_d;
  logic        HALTED, halted_d;
  logic        TAKEN_BRANCH;

  logic        halt_pending_q, halt_pending_d;  // HLT has left ID: fetch stays off
  logic [31:0] if_id_ir_q, if_id_ir_d, if_id_npc_q, if_id_npc_d;
  logic        if_id_valid_q, if_id_valid_d;
  id_ex_t      id_ex_q, id_ex_d, id_new;
  ex_mem_t     ex_mem_q, ex_mem_d;
  mem_wb_t     mem_wb_q, mem_wb_d;

  // ---------------- ID ----------------
  fields_t      id_f;
  instr_class_e id_cls;
  logic         id_use_rs, id_use_rt, load_use;
  logic [31:0]  id_a, id_b;
  logic         wb_we;

  assign id_f   = f_fields(if_id_ir_q);
  assign id_cls = f_class(id_f.op);
  assign wb_we  = mem_wb_q.valid && mem_wb_q.wr && !HALTED;

  always_comb begin
    id_use_rs = if_id_valid_q && (id_cls inside {RR_ALU, RM_ALU, LOAD, STORE, BRANCH});
    id_use_rt = if_id_valid_q && (id_cls inside {RR_ALU, STORE});
    // Register read with write-through of the value retiring this cycle.
    id_a = Reg[id_f.rs];
    if (id_f.rs == 5'd0) id_a = '0;
    else if (wb_we && mem_wb_q.dest == id_f.rs) id_a = mem_wb_q.result;
    id_b = Reg[id_f.rt];
    if (id_f.rt == 5'd0) id_b = '0;
    else if (wb_we && mem_wb_q.dest == id_f.rt) id_b = mem_wb_q.result;

    id_new       = '0;
    id_new.valid = if_id_valid_q;
    id_new.cls   = id_cls;
    id_new.op    = id_f.op;
    id_new.npc   = if_id_npc_q;
    id_new.a     = id_a;
    id_new.b     = id_b;
    id_new.imm   = id_f.imm;
    id_new.rs    = id_f.rs;
    id_new.rt    = id_f.rt;
    id_new.dest  = (id_cls == RR_ALU) ? id_f.rd : id_f.rt;
    id_new.wr    = if_id_valid_q && (id_cls inside {RR_ALU, RM_ALU, LOAD}) &&
                   (id_new.dest != 5'd0);
  end

  // A load in EX cannot forward yet: hold ID one cycle if it needs that value.
  assign load_use = id_ex_q.valid && id_ex_q.cls == LOAD && id_ex_q.wr &&
                    ((id_use_rs && id_f.rs == id_ex_q.dest) ||
                     (id_use_rt && id_f.rt == id_ex_q.dest));

  // ---------------- EX ----------------
  logic [31:0] mem_rdata, ex_mem_fwd, ex_a, ex_b, ex_alu_b, ex_alu;
  logic        ex_taken;

  assign mem_rdata  = Mem[ex_mem_q.alu[9:0]];
  assign ex_mem_fwd = (ex_mem_q.cls == LOAD) ? mem_rdata : ex_mem_q.alu;

  always_comb begin
    ex_a = id_ex_q.a;
    if (id_ex_q.rs == 5'd0) ex_a = '0;
    else if (ex_mem_q.valid && ex_mem_q.wr && ex_mem_q.dest == id_ex_q.rs) ex_a = ex_mem_fwd;
    else if (mem_wb_q.valid && mem_wb_q.wr && mem_wb_q.dest == id_ex_q.rs) ex_a = mem_wb_q.result;
    ex_b = id_ex_q.b;
    if (id_ex_q.rt == 5'd0) ex_b = '0;
    else if (ex_mem_q.valid && ex_mem_q.wr && ex_mem_q.dest == id_ex_q.rt) ex_b = ex_mem_fwd;
    else if (mem_wb_q.valid && mem_wb_q.wr && mem_wb_q.dest == id_ex_q.rt) ex_b = mem_wb_q.result;
  end

  assign ex_alu_b = (id_ex_q.cls == RR_ALU) ? ex_b : id_ex_q.imm;

  mips32_alu u_alu (
    .op     (id_ex_q.op),
    .a      (ex_a),
    .b      (ex_alu_b),
    .result (ex_alu)
  );

  assign ex_taken = id_ex_q.valid && id_ex_q.cls == BRANCH &&
                    ((id_ex_q.op == OP_BEQZ) ? (ex_a == '0) : (ex_a != '0));
  assign TAKEN_BRANCH = ex_taken;

  // ---------------- next state ----------------
  always_comb begin
    pc_d           = PC;
    if_id_ir_d     = if_id_ir_q;
    if_id_npc_d    = if_id_npc_q;
    if_id_valid_d  = if_id_valid_q;
    id_ex_d        = id_new;
    halt_pending_d = halt_pending_q;
    halted_d       = HALTED || (mem_wb_q.valid && mem_wb_q.cls == HALT);

    ex_mem_d       = '0;
    ex_mem_d.valid = id_ex_q.valid;
    ex_mem_d.cls   = id_ex_q.cls;
    ex_mem_d.alu   = ex_alu;
    ex_mem_d.b     = ex_b;
    ex_mem_d.dest  = id_ex_q.dest;
    ex_mem_d.wr    = id_ex_q.wr;

    mem_wb_d        = '0;
    mem_wb_d.valid  = ex_mem_q.valid;
    mem_wb_d.cls    = ex_mem_q.cls;
    mem_wb_d.result = ex_mem_fwd;
    mem_wb_d.dest   = ex_mem_q.dest;
    mem_wb_d.wr     = ex_mem_q.wr;

    if (ex_taken) begin
      // Squash wins over everything younger, including an HLT in ID.
      pc_d          = id_ex_q.npc + id_ex_q.imm;
      if_id_valid_d = 1'b0;
      id_ex_d       = '0;
    end else if (load_use) begin
      id_ex_d = '0;
    end else if (halt_pending_q || (if_id_valid_q && id_cls == HALT)) begin
      if_id_valid_d  = 1'b0;
      halt_pending_d = 1'b1;
    end else begin
      pc_d          = PC + 32'd1;
      if_id_ir_d    = Mem[PC[9:0]];
      if_id_npc_d   = PC + 32'd1;
      if_id_valid_d = 1'b1;
    end

    if (HALTED) pc_d = PC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC             <= '0;
      HALTED         <= 1'b0;
      halt_pending_q <= 1'b0;
      if_id_ir_q     <= '0;
      if_id_npc_q    <= '0;
      if_id_valid_q  <= 1'b0;
      id_ex_q        <= '0;
      ex_mem_q       <= '0;
      mem_wb_q       <= '0;
    end else begin
      PC             <= pc_d;
      HALTED         <= halted_d;
      halt_pending_q <= halt_pending_d;
      if_id_ir_q     <= if_id_ir_d;
      if_id_npc_q    <= if_id_npc_d;
      if_id_valid_q  <= if_id_valid_d;
      id_ex_q        <= id_ex_d;
      ex_mem_q       <= ex_mem_d;
      mem_wb_q       <= mem_wb_d;
    end
  end

  // Storage arrays: no reset, also loaded from outside before a run.
  always @(posedge clk) begin
    if (wb_we) Reg[mem_wb_q.dest] <= mem_wb_q.result;
    if (ex_mem_q.valid && ex_mem_q.cls == STORE && !HALTED)
      Mem[ex_mem_q.alu[9:0]] <= ex_mem_q.b;
  end

  assign halted = HALTED;

endmodule

// File: tb/tb_mips32_processor.sv
module tb_mips32_processor;

  localparam logic [5:0] T_ADD = 6'b000000, T_SUB = 6'b000001, T_AND = 6'b000010;
  localparam logic [5:0] T_OR = 6'b000011, T_SLT = 6'b000100, T_MUL = 6'b000101;
  localparam logic [5:0] T_LW = 6'b001000, T_SW = 6'b001001, T_ADDI = 6'b001010;
  localparam logic [5:0] T_SUBI = 6'b001011, T_SLTI = 6'b001100;
  localparam logic [5:0] T_BNEQZ = 6'b001101, T_BEQZ = 6'b001110;
  localparam logic [31:0] T_HLT = 32'hFC00_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic halted;

  int n_checks = 0;
  int n_fail   = 0;

  mips32_processor dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .halted (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] r_type(input logic [5:0] op, input int rs, input int rt, input int rd);
    logic [4:0] s, t, d;
    s = rs[4:0]; t = rt[4:0]; d = rd[4:0];
    return {op, s, t, d, 11'd0};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input int rs, input int rt, input int imm);
    logic [4:0] s, t;
    logic [15:0] i16;
    s = rs[4:0]; t = rt[4:0]; i16 = imm[15:0];
    return {op, s, t, i16};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold reset, clear memory, set Reg[k]=k.
  task automatic clear_state();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 1024; i++) dut.Mem[i] = 32'd0;
    for (int i = 0; i < 32; i++) dut.Reg[i] = i;
  endtask

  // Release reset on a falling edge and count rising edges until halted.
  // tmask[k] holds TAKEN_BRANCH as seen during cycle k.
  task automatic run_prog(input string tag, input int max_cycles, output int cycles,
                          output logic [63:0] tmask);
    cycles = 0;
    tmask  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tmask[0] = dut.TAKEN_BRANCH;
    while (!halted && cycles < max_cycles) begin
      @(negedge clk);
      cycles++;
      if (cycles < 64) tmask[cycles] = dut.TAKEN_BRANCH;
    end
    check({tag, "_halted"}, {31'd0, halted}, 32'd1);
    $display("run %s: %0d cycles", tag, cycles);
  endtask

  // R2 change monitor for the factorial loop.
  logic        mon_en = 1'b0;
  logic [31:0] r2_prev;
  logic [31:0] r2_hist[$];
  always @(negedge clk) begin
    if (mon_en && dut.Reg[2] !== r2_prev) begin
      r2_hist.push_back(dut.Reg[2]);
      r2_prev = dut.Reg[2];
    end
  end

  task automatic load_factorial();
    dut.Mem[0]  = i_type(T_ADDI, 0, 10, 200);
    dut.Mem[1]  = i_type(T_ADDI, 0, 2, 1);
    dut.Mem[2]  = r_type(T_OR, 20, 20, 20);
    dut.Mem[3]  = i_type(T_LW, 10, 3, 0);
    dut.Mem[4]  = r_type(T_OR, 20, 20, 20);
    dut.Mem[5]  = r_type(T_MUL, 2, 3, 2);
    dut.Mem[6]  = i_type(T_SUBI, 3, 3, 1);
    dut.Mem[7]  = r_type(T_OR, 20, 20, 20);
    dut.Mem[8]  = i_type(T_BNEQZ, 3, 0, -4);
    dut.Mem[9]  = i_type(T_SW, 10, 2, -2);
    dut.Mem[10] = T_HLT;
    dut.Mem[200] = 32'd10;
  endtask

  logic [31:0] fact_exp [10] = '{32'd1, 32'd10, 32'd90, 32'd720, 32'd5040, 32'd30240,
                                 32'd151200, 32'd604800, 32'd1814400, 32'd3628800};

  initial begin
    int cyc;
    logic [63:0] tm;

    // ---- reset state ----
    #1 rst_n = 1'b0;
    #1;
    check("rst_pc", dut.PC, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);

    // ---- back-to-back ALU dependencies, no stall ----
    clear_state();
    dut.Mem[0] = i_type(T_ADDI, 0, 1, 5);
    dut.Mem[1] = r_type(T_ADD, 1, 1, 2);
    dut.Mem[2] = r_type(T_SUB, 0, 1, 3);
    dut.Mem[3] = r_type(T_SLT, 3, 1, 11);
    dut.Mem[4] = r_type(T_AND, 2, 1, 12);
    dut.Mem[5] = r_type(T_OR, 2, 1, 13);
    dut.Mem[6] = i_type(T_SLTI, 1, 14, -1);
    dut.Mem[7] = i_type(T_ADDI, 0, 0, 7);
    dut.Mem[8] = r_type(T_ADD, 0, 0, 15);
    dut.Mem[9] = T_HLT;
    run_prog("alu", 200, cyc, tm);
    check("alu_cycles", cyc, 32'd14);
    check("alu_tmask", tm[31:0], 32'd0);
    check("alu_r1", dut.Reg[1], 32'd5);
    check("alu_r2", dut.Reg[2], 32'd10);
    check("alu_r3_sub", dut.Reg[3], 32'hFFFF_FFFB);
    check("alu_r11_slt", dut.Reg[11], 32'd1);
    check("alu_r12_and", dut.Reg[12], 32'd0);
    check("alu_r13_or", dut.Reg[13], 32'd15);
    check("alu_r14_slti", dut.Reg[14], 32'd0);
    check("alu_r0", dut.Reg[0], 32'd0);
    check("alu_r15_no_r0_fwd", dut.Reg[15], 32'd0);

    // ---- load-use stall ----
    clear_state();
    dut.Mem[0] = i_type(T_LW, 0, 4, 0);
    dut.Mem[1] = r_type(T_ADD, 4, 4, 5);
    dut.Mem[2] = T_HLT;
    run_prog("ldu", 200, cyc, tm);
    check("ldu_cycles", cyc, 32'd8);
    check("ldu_r4", dut.Reg[4], 32'h2004_0000);
    check("ldu_r5", dut.Reg[5], 32'h4008_0000);

    // ---- taken branch squash, then not-taken branch ----
    clear_state();
    dut.Mem[0] = i_type(T_BEQZ, 0, 0, 2);
    dut.Mem[1] = i_type(T_ADDI, 0, 6, 7);
    dut.Mem[2] = i_type(T_SW, 0, 6, 100);
    dut.Mem[3] = i_type(T_ADDI, 0, 7, 9);
    dut.Mem[4] = i_type(T_BNEQZ, 0, 0, 1);
    dut.Mem[5] = i_type(T_ADDI, 0, 8, 11);
    dut.Mem[6] = T_HLT;
    dut.Mem[100] = 32'h0000_1234;
    run_prog("br", 200, cyc, tm);
    check("br_cycles", cyc, 32'd11);
    check("br_tmask", tm[31:0], 32'h0000_0004);
    check("br_r6_squashed", dut.Reg[6], 32'd6);
    check("br_mem100", dut.Mem[100], 32'h0000_1234);
    check("br_r7_target", dut.Reg[7], 32'd9);
    check("br_r8_fallthru", dut.Reg[8], 32'd11);

    // ---- wrong-path HLT ----
    clear_state();
    dut.Mem[0] = i_type(T_BEQZ, 0, 0, 1);
    dut.Mem[1] = T_HLT;
    dut.Mem[2] = i_type(T_ADDI, 0, 9, 3);
    dut.Mem[3] = T_HLT;
    run_prog("wphlt", 200, cyc, tm);
    check("wphlt_cycles", cyc, 32'd9);
    check("wphlt_r9", dut.Reg[9], 32'd3);

    // ---- factorial ----
    clear_state();
    load_factorial();
    r2_hist.delete();
    r2_prev = dut.Reg[2];
    mon_en  = 1'b1;
    run_prog("fact", 1000, cyc, tm);
    mon_en  = 1'b0;
    check("fact_r2", dut.Reg[2], 32'd3628800);
    check("fact_mem198", dut.Mem[198], 32'd3628800);
    check("fact_mem200", dut.Mem[200], 32'd10);
    check("fact_r0", dut.Reg[0], 32'd0);
    check("fact_r3", dut.Reg[3], 32'd0);
    check("fact_r20", dut.Reg[20], 32'd20);
    check("fact_r2_steps", r2_hist.size(), 32'd10);
    for (int i = 0; i < 10 && i < r2_hist.size(); i++)
      check($sformatf("fact_r2_step%0d", i), r2_hist[i], fact_exp[i]);
    // Halted core must stay put.
    repeat (5) @(negedge clk);
    check("fact_pc_frozen", dut.PC, 32'd11);
    check("fact_still_halted", {31'd0, halted}, 32'd1);

    // ---- reset in the middle of the loop ----
    clear_state();
    load_factorial();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("mid_not_halted", {31'd0, halted}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_pc", dut.PC, 32'd0);
    check("mid_rst_halted", {31'd0, halted}, 32'd0);
    check("mid_keep_r10", dut.Reg[10], 32'd200);
    check("mid_keep_mem200", dut.Mem[200], 32'd10);
    check("mid_keep_mem8", dut.Mem[8], 32'h3460_FFFC);
    check("mid_mem198_unwritten", dut.Mem[198], 32'd0);
    run_prog("mid", 1000, cyc, tm);
    check("mid_r2", dut.Reg[2], 32'd3628800);
    check("mid_mem198", dut.Mem[198], 32'd3628800);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips32_processor.md
# mips32_processor

Five-stage pipelined 32-bit MIPS-subset CPU (IF, ID, EX, MEM, WB) with a unified instruction/data memory and a 32×32 register file. It is the top compute block. Programs and data are preloaded hierarchically into `Mem` and `Reg`, and the core runs from PC 0 until an HLT instruction retires. Data hazards are resolved in hardware, so correct code needs no filler instructions.

## Interface
- No parameters. Fixed sizes: 32 registers, 1024-word memory.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `halted`  out  1  high once an HLT has retired; reset value 0.
- Hierarchically visible state, names fixed:
  - `Reg[0:31]`, 32-bit register file.
  - `Mem[0:1023]`, 32-bit word-addressed memory.
  - `PC`, `HALTED`, `TAKEN_BRANCH`.

## Operation
- Instruction fields:
  - op [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0].
  - imm is sign-extended to 32 bits.
- R-type, rd = rs OP rt:
  - ADD 000000, SUB 000001, AND 000010, OR 000011.
  - SLT 000100: signed compare, result 1 or 0.
  - MUL 000101: low 32 bits of the product.
- I-type:
  - LW 001000: rt = Mem[rs+imm].
  - SW 001001: Mem[rs+imm] = rt.
  - ADDI 001010, SUBI 001011, SLTI 001100: rt = rs OP imm.
  - BNEQZ 001101, branch if rs≠0; BEQZ 001110, branch if rs==0. Target = PC_of_branch + 1 + imm, in word units.
  - HLT 111111.
- Any other opcode executes as a NOP.
- Arithmetic wraps modulo 2^32. Memory address = ALU result [9:0].
- R0 always reads 0. Writes to R0 are discarded and are never forwarded.
- Register file: written in WB. An ID read of the register being written in the same cycle returns the new value.
- Forwarding: EX operands, including the branch condition, come from EX/MEM (priority) or MEM/WB when that stage's destination matches rs/rt.
- Load-use: an instruction in ID that reads the rt of an LW in EX stalls one cycle. PC and IF/ID hold; a bubble is inserted into EX.
- Branch resolves in EX.
  - If taken: PC ← target, TAKEN_BRANCH=1 for that cycle, and the two younger instructions (IF/ID, and the one fetched that cycle) become bubbles.
  - Squashed instructions never write Reg or Mem and never halt the core.
- HLT:
  - When a non-squashed HLT is in ID, fetch stops: PC freezes and bubbles are issued.
  - When the HLT reaches WB, HALTED=1 and all Reg, Mem and PC updates cease permanently until reset.
- A squash in the same cycle takes priority over HLT fetch-stop.
- Reset (asynchronous, at any time):
  - PC=0, HALTED=0, TAKEN_BRANCH=0.
  - All pipeline registers become bubbles.
  - Reg and Mem are not reset.

## Timing
- Instruction fetched in cycle n writes Reg at the end of cycle n+4, with no stalls.
- Throughput is 1 instruction per cycle. Costs:
  - Load-use: +1 cycle.
  - Taken branch: +2 cycles.
  - Not-taken branch: no penalty.
- MUL and all ALU ops are single-cycle combinational.
- Memory reads are combinational; SW writes at the end of MEM.
- IF and MEM access `Mem` through independent read ports.

## Structure
- Shared package `mips32_pkg`:
  - Opcode localparams.
  - Instruction-class enum: RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP.
  - Field-slice helpers.
- Sub-module `mips32_alu`: combinational, inputs op, a, b; output result for all ALU ops and address add.
- The top module holds the pipeline registers, hazard unit, regfile and memory.

## Test plan
- Factorial. Preload:
  - Mem[0..10]: ADDI R10,R0,200; ADDI R2,R0,1; OR R20,R20,R20; LW R3,0(R10); OR; MUL R2,R2,R3; SUBI R3,R3,1; OR; BNEQZ R3,-4; SW R2,-2(R10); HLT.
  - Mem[200]=10; Reg[k]=k.
  - Required: R2 steps through 10, 90, 720, …, 3628800; Mem[198]=3628800; Mem[200]=10; halted=1; R0 still 0.
- Back-to-back dependency: ADDI R1,R0,5; ADD R2,R1,R1 → R2=10 with no stall.
- Load-use: LW R4,0(R0) with Mem[0]=… as data, then ADD R5,R4,R4.
  - Required: one-cycle stall; R5 = 2×loaded value.
- Branch squash: BEQZ R0,+2 followed by ADDI R6,R0,7 and SW.
  - Required: R6 and Mem unchanged; target instruction executes.
  - A not-taken BNEQZ R0 executes the fall-through path.
- Wrong-path HLT: a taken branch over an HLT → the core does not halt.
- Reset mid-run: assert rst_n=0 during the loop.
  - Required: PC=0 and halted=0 immediately; Reg and Mem keep their contents.
